conway_cell_scanner: RTL
========================

Name: conway_cell_scanner

Overview:
- Read-out counterpart to the cell loader of the `conway` core.
- On a start pulse it walks the board in raster order over the core's row-wide read port. It emits the 16-bit address of every live cell on a valid/ready stream, using the same {row[7:0], col[7:0]} format the core accepts on its `addr` load input.
- Used for display, dumping a generation, and scoreboarding in benches. It also reports the live-cell count.

Parameters:
- ROWS, 16, board height in rows; 1..256.
- COLS, 16, board width in columns; 1..256.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to scan; honoured only in IDLE.
- busy  out  1  high from start acceptance until done is asserted.
- done  out  1  one-cycle pulse after the last cell is handshaken.
- live_count  out  17  number of live cells found in the last completed scan.
- rd_en  out  1  row read strobe to the core.
- rd_row  out  8  row index for the read.
- rd_data  in  COLS  row contents; bit c = column c. Valid exactly one cycle after rd_en.
- cell_valid  out  1  cell_addr holds a live cell.
- cell_ready  in  1  sink accepts the cell.
- cell_addr  out  16  {row, col} of the live cell.

Behaviour:
- Reset (rst=0, async) clears:
  - state=IDLE;
  - busy, done, rd_en, cell_valid = 0;
  - rd_row, cell_addr, live_count = 0;
  - internal row/col counters and row buffer.
- Reset mid-scan abandons the scan with no done pulse.
- States:
  - IDLE: start=1 → FETCH; clears the running count; busy=1 from the next cycle.
  - FETCH (1 cycle): rd_en=1, rd_row=row → WAIT.
  - WAIT (1 cycle): captures rd_data into the row buffer; col=0 → SCAN.
  - SCAN (one column per cycle):
    - Dead bit: col advances.
    - Live bit: cell_addr<={row,col}, cell_valid<=1 next cycle, and the count increments. The scan continues only once the held cell is handshaken.
    - After col=COLS-1 is processed: row<ROWS-1 → row+1, FETCH; else → DRAIN.
  - DRAIN: waits for the outstanding cell to be handshaken, then → DONE.
  - DONE (1 cycle): done=1; live_count<=running count; busy=0 next cycle → IDLE.
- Stream rules:
  - Handshake occurs on a cycle with cell_valid && cell_ready.
  - cell_addr is stable while cell_valid=1 && cell_ready=0.
  - No cell is dropped or duplicated.
  - cell_valid may stay high across back-to-back cells when cell_ready=1, giving 1 cell per cycle.
  - The scanner stalls on a live bit while the previous cell is unaccepted.
- Ordering: strictly ascending row, then ascending column.
- Counting and widths:
  - cell_addr upper byte = row, lower byte = col; zero-extended when ROWS/COLS < 256.
  - live_count saturates never; 17 bits covers 65536.
  - live_count holds until the next DONE.
- Timing: with cell_ready held at 1 and an all-dead board, done rises exactly ROWS*(COLS+2)+1 cycles after the start cycle.
- start while busy is ignored. start in the same cycle as done is ignored.
- Boundaries:
  - A live cell at (ROWS-1, COLS-1) is emitted before done.
  - ROWS=1 or COLS=1 is legal.
  - A stall persists indefinitely if cell_ready stays 0; busy stays 1.

Test Plan:
1. Glider: board live at (2,0),(1,2),(2,2),(3,2),(3,1); start; cell_ready=1 → cells 0x0102, 0x0200, 0x0202, 0x0301, 0x0302 in that order; done once; live_count=5.
2. Empty board, defaults, cell_ready=1 → no cell_valid; done exactly 289 cycles after start; live_count=0.
3. Backpressure: glider board; cell_ready toggles 0/1 pseudo-randomly → same 5 addresses, each held stable while stalled; done only after 0x0302 is accepted.
4. Full board (all 256 live), cell_ready=1 → 256 consecutive cells 0x0000..0x0F0F, back-to-back cell_valid within each row; live_count=256.
5. start pulsed again mid-scan → ignored; exactly one done; live_count unchanged from the single-scan result.
6. rst asserted mid-scan while cell_valid=1 → outputs zero immediately; after release, a new start produces a full correct scan.

Source files
------------

// File: rtl/conway_cell_scanner.sv
// ----------------------------------------------------------------------------
// conway_cell_scanner
//
// Walks the board of the conway core in raster order through its row-wide
// read port and streams out the {row, col} address of every live cell on a
// valid/ready interface. At the end of each scan it reports the live count.
//
// Ports:
//   clk          rising-edge system clock
//   rst          asynchronous, active-low reset
//   start        one-cycle scan request, honoured only when idle
//   busy         high from start acceptance until the done cycle ends
//   done         one-cycle pulse once the last live cell has been accepted
//   live_count   live cells found by the last completed scan
//   rd_en        row read strobe to the core
//   rd_row       row index for the read
//   rd_data      row contents (bit c = column c), valid one cycle after rd_en
//   cell_valid   cell_addr holds a live cell
//   cell_ready   sink accepts the cell
//   cell_addr    {row[7:0], col[7:0]} of the live cell
// ----------------------------------------------------------------------------
module conway_cell_scanner #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [16:0]     live_count,
    output logic            rd_en,
    output logic [7:0]      rd_row,
    input  logic [COLS-1:0] rd_data,
    output logic            cell_valid,
    input  logic            cell_ready,
    output logic [15:0]     cell_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    state_t       state_q;
    state_t       state_d;
    logic [7:0]   row_q;
    logic [7:0]   col_q;
    logic [16:0]  running_q;
    // Padded to 256 bits so any 8-bit column index is in range; the unused
    // upper bits are constant zero.
    logic [255:0] row_buf;

    logic bit_live;
    logic slot_free;
    logic last_col;
    logic last_row;
    logic load_cell;
    logic advance;

    assign bit_live  = row_buf[col_q];
    // The output slot can take a new cell if it is empty or being accepted now.
    assign slot_free = !cell_valid || cell_ready;
    assign last_col  = (col_q == LAST_COL);
    assign last_row  = (row_q == LAST_ROW);

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign rd_en  = (state_q == S_FETCH);
    assign rd_row = row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        load_cell = 1'b0;
        advance   = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_SCAN;
            S_SCAN: begin
                // A live bit waits here until the held cell has gone.
                if (!bit_live || slot_free) begin
                    advance   = 1'b1;
                    load_cell = bit_live;
                    if (last_col) begin
                        if (!last_row) begin
                            state_d = S_FETCH;
                        end else if (bit_live || !slot_free) begin
                            state_d = S_DRAIN;
                        end else begin
                            // Nothing outstanding: skip the drain cycle.
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DRAIN: if (slot_free) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the row buffer is plain flops, not a RAM, so it takes the async
    // reset along with the rest of the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q      <= '0;
            col_q      <= '0;
            running_q  <= '0;
            row_buf    <= '0;
            cell_valid <= 1'b0;
            cell_addr  <= '0;
            live_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values regardless of statement order.
            if (state_q == S_IDLE && start) begin
                row_q     <= '0;
                running_q <= '0;
            end

            if (state_q == S_WAIT) begin
                row_buf <= 256'(rd_data);
                col_q   <= '0;
            end

            if (advance) begin
                if (last_col) begin
                    col_q <= '0;
                    if (!last_row) row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end

            if (load_cell) begin
                cell_addr  <= {row_q, col_q};
                cell_valid <= 1'b1;
                running_q  <= running_q + 17'd1;
            end else if (cell_ready) begin
                cell_valid <= 1'b0;
            end

            if (state_q == S_DONE) live_count <= running_q;
        end
    end

endmodule
